bch_bm_solver: RTL and testbench

- Berlekamp-Massey solver for the BCH decoder over GF(2^13), field polynomial x^13+x^4+x^3+x+1.
- Consumes the 2T syndromes from the syndrome stage and produces the error-locator polynomial Lambda(x) for the Chien search.
- Field inversion of the discrepancy is not done internally. The block drives the team's sequential start/done GF(2^13) inverter through the inv_* ports and consumes its output.

---
 rtl/bch_bm_solver.sv | 227 ++++++++++++++++++++++
 tb/tb_bch_bm_solver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_bm_solver.sv
// Berlekamp-Massey error-locator solver for the GF(2^13) BCH decoder.
// Discrepancy inversion is delegated to an external start/done inverter.
module bch_bm_solver #(
    parameter int T = 4,
    parameter int M = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*T*M-1:0]     syn_in,
    output logic                 busy,
    output logic                 done,
    output logic [(T+1)*M-1:0]   lambda_out,
    output logic [3:0]           lambda_deg,
    output logic                 fail,
    output logic                 inv_start,
    output logic [M-1:0]         inv_a,
    input  logic [M-1:0]         inv_b,
    input  logic                 inv_done
);

    localparam logic [M-1:0] POLY = 13'h001B;

    typedef enum logic [2:0] {
        S_IDLE, S_DISC, S_CHK, S_INV, S_UPD, S_NEXT, S_FIN
    } state_t;

    function automatic logic [M-1:0] gf_mul(
        input logic [M-1:0] a,
        input logic [M-1:0] b
    );
        logic [M-1:0] p;
        logic [M-1:0] sh;
        p  = '0;
        sh = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) p = p ^ sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY : '0);
        end
        return p;
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [M-1:0]   r_syn [0:2*T-1];
    logic [M-1:0]   r_lam [0:T];
    logic [M-1:0]   r_b   [0:T];
    logic [3:0]     r_l;
    logic [3:0]     r_r;
    logic [3:0]     r_idx;
    logic [M-1:0]   r_delta;
    logic [M-1:0]   r_dinv;
    logic [M-1:0]   r_bprev;
    logic           r_chg;
    logic [(T+1)*M-1:0] r_lam_out;
    logic [3:0]     r_deg;
    logic           r_fail;

    logic           w_last;
    logic           w_grow;
    logic [M-1:0]   w_lam_i;
    logic [M-1:0]   w_b_i;
    logic [M-1:0]   w_s;
    logic [M-1:0]   w_ma_a;
    logic [M-1:0]   w_ma_b;
    logic [M-1:0]   w_pa;
    logic [M-1:0]   w_pb;

    assign w_last = (r_idx == 4'(T));
    assign w_grow = ({r_l, 1'b0} <= ({1'b0, r_r} - 5'd1));

    // Select coefficient idx of Lambda/B and syndrome S_(r-idx), zero below S_1.
    always_comb begin
        w_lam_i = '0;
        w_b_i   = '0;
        w_s     = '0;
        for (int k = 0; k <= T; k++) begin
            if (r_idx == 4'(k)) begin
                w_lam_i = r_lam[k];
                w_b_i   = r_b[k];
            end
        end
        for (int k = 0; k < 2*T; k++) begin
            if ({1'b0, r_r} == ({1'b0, r_idx} + 5'(k + 1))) w_s = r_syn[k];
        end
    end

    // Two GF multipliers: A is shared by discrepancy MAC and Lambda update, B scales old Lambda into B.
    always_comb begin
        w_ma_a = (r_state == S_UPD) ? r_delta : w_lam_i;
        w_ma_b = (r_state == S_UPD) ? r_bprev : w_s;
        w_pa   = gf_mul(w_ma_a, w_ma_b);
        w_pb   = gf_mul(r_dinv, w_lam_i);
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        inv_start = 1'b0;
        inv_a     = '0;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_DISC;
            S_DISC: begin
                busy = 1'b1;
                if (w_last) w_next = S_CHK;
            end
            S_CHK: begin
                busy = 1'b1;
                if (r_delta == '0) begin
                    w_next = S_NEXT;
                end else if (w_grow) begin
                    inv_start = 1'b1;
                    inv_a     = r_delta;
                    w_next    = S_INV;
                end else begin
                    w_next = S_UPD;
                end
            end
            S_INV: begin
                busy  = 1'b1;
                inv_a = r_delta;
                if (inv_done) w_next = S_UPD;
            end
            S_UPD: begin
                busy = 1'b1;
                if (w_last) w_next = S_NEXT;
            end
            S_NEXT: begin
                busy   = 1'b1;
                w_next = (r_r == 4'(2*T)) ? S_FIN : S_DISC;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Datapath: syndrome capture, discrepancy MAC, coefficient updates, result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2*T; k++) r_syn[k] <= '0;
            for (int k = 0; k <= T; k++) begin
                r_lam[k] <= '0;
                r_b[k]   <= '0;
            end
            r_l       <= '0;
            r_r       <= '0;
            r_idx     <= '0;
            r_delta   <= '0;
            r_dinv    <= '0;
            r_bprev   <= '0;
            r_chg     <= 1'b0;
            r_lam_out <= '0;
            r_deg     <= '0;
            r_fail    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 2*T; k++) r_syn[k] <= syn_in[k*M +: M];
                        for (int k = 0; k <= T; k++) begin
                            r_lam[k] <= (k == 0) ? M'(1) : '0;
                            r_b[k]   <= (k == 0) ? M'(1) : '0;
                        end
                        r_l     <= '0;
                        r_r     <= 4'd1;
                        r_idx   <= '0;
                        r_delta <= '0;
                    end
                end
                S_DISC: begin
                    r_delta <= r_delta ^ w_pa;
                    r_idx   <= w_last ? '0 : r_idx + 4'd1;
                end
                S_CHK: begin
                    r_bprev <= '0;
                    r_chg   <= w_grow;
                    if (r_delta == '0) begin
                        r_b[0] <= '0;
                        for (int k = 1; k <= T; k++) r_b[k] <= r_b[k-1];
                    end
                end
                S_INV: begin
                    if (inv_done) r_dinv <= inv_b;
                end
                S_UPD: begin
                    for (int k = 0; k <= T; k++) begin
                        if (r_idx == 4'(k)) begin
                            r_lam[k] <= r_lam[k] ^ w_pa;
                            r_b[k]   <= r_chg ? w_pb : r_bprev;
                        end
                    end
                    r_bprev <= w_b_i;
                    r_idx   <= w_last ? '0 : r_idx + 4'd1;
                    if (w_last && r_chg) r_l <= r_r - r_l;
                end
                S_NEXT: begin
                    r_delta <= '0;
                    if (r_r == 4'(2*T)) begin
                        for (int k = 0; k <= T; k++) r_lam_out[k*M +: M] <= r_lam[k];
                        r_deg  <= r_l;
                        r_fail <= (r_l > 4'(T));
                    end else begin
                        r_r <= r_r + 4'd1;
                    end
                end
                S_FIN: ;
                default: ;
            endcase
        end
    end

    assign lambda_out = r_lam_out;
    assign lambda_deg = r_deg;
    assign fail       = r_fail;

endmodule

// File: tb/tb_bch_bm_solver.sv
// Directed bench for bch_bm_solver with a variable-latency inverter model.
// Expected locators are worked out by hand from the chosen error patterns.
module tb_bch_bm_solver;

    localparam int T  = 4;
    localparam int M  = 13;
    localparam int SW = 2*T*M;
    localparam int LW = (T+1)*M;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] syn_in = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] lambda_out;
    logic [3:0]    lambda_deg;
    logic          fail;
    logic          inv_start;
    logic [M-1:0]  inv_a;
    logic [M-1:0]  inv_b = '0;
    logic          inv_done = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int inv_dly = 1;
    int inv_cnt = 0;
    bit inv_busy = 1'b0;
    logic [M-1:0] inv_a_seen = '0;

    logic [M-1:0]  ex [5];
    logic [SW-1:0] sv;
    logic [M-1:0]  x3, x4, x5, s5, c5, p5, zz;
    bit            found;
    bit            saw;
    int            c0, cyc;
    int            dl [3] = '{1, 14, 40};

    bch_bm_solver #(.T(T), .M(M)) dut (
        .clk(clk), .rst(rst), .start(start), .syn_in(syn_in),
        .busy(busy), .done(done), .lambda_out(lambda_out),
        .lambda_deg(lambda_deg), .fail(fail),
        .inv_start(inv_start), .inv_a(inv_a),
        .inv_b(inv_b), .inv_done(inv_done)
    );

    always #5 clk = ~clk;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-1:0] p;
        p = '0;
        for (int i = 0; i < M; i++) if (b[i]) p = p ^ ({13'h0, a} << i);
        for (int i = 2*M-2; i >= M; i--) if (p[i]) p = p ^ (26'h201B << (i - M));
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] gf_pow(input logic [M-1:0] a, input int n);
        logic [M-1:0] r;
        r = 13'h1;
        for (int i = 0; i < n; i++) r = gf_mul(r, a);
        return r;
    endfunction

    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
        logic [M-1:0] r;
        logic [M-1:0] b;
        int e;
        r = 13'h1;
        b = a;
        e = 8190;
        while (e != 0) begin
            if (e[0]) r = gf_mul(r, b);
            b = gf_mul(b, b);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] lam5(input logic [M-1:0] c0_, input logic [M-1:0] c1,
                                           input logic [M-1:0] c2, input logic [M-1:0] c3,
                                           input logic [M-1:0] c4);
        return {c4, c3, c2, c1, c0_};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build_syn(input int n, output logic [SW-1:0] s);
        logic [M-1:0] acc;
        s = '0;
        for (int j = 1; j <= 2*T; j++) begin
            acc = '0;
            for (int e = 0; e < n; e++) acc = acc ^ gf_pow(ex[e], j);
            s[(j-1)*M +: M] = acc;
        end
    endtask

    task automatic run(input logic [SW-1:0] syn, input bit poke);
        int n;
        @(negedge clk);
        syn_in = syn;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (poke) begin
            repeat (3) @(negedge clk);
            syn_in = '0;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_during_poke", busy, 1);
        end
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        check("busy_low_at_done", busy, 0);
    endtask

    task automatic after_done(input logic [LW-1:0] lam, input logic f);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("lambda_held", lambda_out, lam);
        check("fail_held", fail, f);
    endtask

    // Inverter model: answers each request after inv_dly cycles, even across a reset.
    initial begin
        forever begin
            @(negedge clk);
            if (inv_start) begin
                inv_busy   = 1'b1;
                inv_cnt++;
                inv_a_seen = inv_a;
                repeat (inv_dly) @(posedge clk);
                #1;
                inv_b    = gf_inv(inv_a_seen);
                inv_done = 1'b1;
                @(posedge clk);
                #1;
                inv_done = 1'b0;
                inv_b    = '0;
                inv_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_inv_start", inv_start, 0);
        check("rst_inv_a", inv_a, 0);
        check("rst_lambda", lambda_out, 0);
        check("rst_deg", lambda_deg, 0);
        rst = 1'b0;

        c0 = inv_cnt;
        run('0, 1'b0);
        check("zero_lambda", lambda_out, lam5(13'h1, 0, 0, 0, 0));
        check("zero_deg", lambda_deg, 0);
        check("zero_fail", fail, 0);
        check("zero_inv_cnt", inv_cnt - c0, 0);

        for (int j = 0; j < 2*T; j++) sv[j*M +: M] = 13'h1;
        inv_dly = 1;
        c0 = inv_cnt;
        run(sv, 1'b0);
        check("one_lambda", lambda_out, lam5(13'h1, 13'h1, 0, 0, 0));
        check("one_deg", lambda_deg, 1);
        check("one_fail", fail, 0);
        check("one_inv_cnt", inv_cnt - c0, 1);
        check("one_inv_a", inv_a_seen, 13'h1);
        after_done(lam5(13'h1, 13'h1, 0, 0, 0), 1'b0);

        for (int j = 1; j <= 2*T; j++) sv[(j-1)*M +: M] = 13'(1 << j);
        for (int d = 0; d < 3; d++) begin
            inv_dly = dl[d];
            c0 = inv_cnt;
            run(sv, 1'b0);
            check("alpha_lambda", lambda_out, lam5(13'h1, 13'h2, 0, 0, 0));
            check("alpha_deg", lambda_deg, 1);
            check("alpha_fail", fail, 0);
            check("alpha_inv_cnt", inv_cnt - c0, 1);
            check("alpha_inv_a", inv_a_seen, 13'h2);
        end

        inv_dly = 3;
        ex[0] = 13'h1;
        ex[1] = 13'h2;
        build_syn(2, sv);
        run(sv, 1'b1);
        check("two_lambda", lambda_out, lam5(13'h1, 13'h3, 13'h2, 0, 0));
        check("two_deg", lambda_deg, 2);
        check("two_fail", fail, 0);
        after_done(lam5(13'h1, 13'h3, 13'h2, 0, 0), 1'b0);
        repeat (4) @(negedge clk);
        check("two_no_restart", busy, 0);

        found = 1'b0;
        x4 = '0;
        x5 = '0;
        for (int k = 2; k < 100 && !found; k++) begin
            x3 = gf_pow(13'h2, k);
            s5 = 13'h1 ^ 13'h2 ^ x3;
            c5 = 13'h1 ^ gf_pow(13'h2, 3) ^ gf_pow(x3, 3);
            if (s5 != '0) begin
                p5 = gf_mul(c5, gf_inv(s5)) ^ gf_mul(s5, s5);
                if (p5 != '0) begin
                    for (int z = 1; z < 8192 && !found; z++) begin
                        zz = 13'(z);
                        if ((gf_mul(zz, zz) ^ gf_mul(s5, zz) ^ p5) == '0) begin
                            x4 = zz;
                            x5 = zz ^ s5;
                            if (x4 != 13'h1 && x4 != 13'h2 && x4 != x3 &&
                                x5 != 13'h1 && x5 != 13'h2 && x5 != x3)
                                found = 1'b1;
                        end
                    end
                end
            end
        end
        check("five_pattern_found", found, 1);
        ex[2] = x3;
        ex[3] = x4;
        ex[4] = x5;
        build_syn(5, sv);
        inv_dly = 2;
        run(sv, 1'b0);
        check("five_fail", fail, 1);
        check("five_deg_gt_T", lambda_deg > 4'(T), 1);
        @(negedge clk);
        check("five_fail_held", fail, 1);

        inv_dly = 40;
        for (int j = 0; j < 2*T; j++) sv[j*M +: M] = 13'h1;
        c0 = inv_cnt;
        @(negedge clk);
        syn_in = sv;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (inv_cnt == c0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_wait", inv_cnt - c0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        cyc = 0;
        while (inv_busy && cyc < 200) begin
            @(negedge clk);
            if (busy || done) saw = 1'b1;
            cyc++;
        end
        check("stale_done_delivered", inv_busy, 0);
        repeat (3) begin
            @(negedge clk);
            if (busy || done) saw = 1'b1;
        end
        check("stale_stays_idle", saw, 0);
        check("stale_lambda", lambda_out, 0);
        check("stale_deg", lambda_deg, 0);
        check("stale_fail", fail, 0);
        check("stale_inv_start", inv_start, 0);
        check("stale_inv_a", inv_a, 0);

        inv_dly = 1;
        run('0, 1'b0);
        check("post_rst_lambda", lambda_out, lam5(13'h1, 0, 0, 0, 0));
        check("post_rst_deg", lambda_deg, 0);
        check("post_rst_fail", fail, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
